// File: rtl/sa_2d.sv
`default_nettype none
// ============================================================================
// Module      : sa_2d
// Description : Output-stationary 2-D systolic array of multiply-accumulate
//               PEs, HPE rows by VPE columns. Row operands enter on the left
//               and shift right one PE per clock. Column operands enter on
//               the top and shift down one PE per clock. Each PE accumulates
//               a_in*b_in in place, and the sum is exposed on Y.
// Ports       : CLK - rising-edge clock
//               RST - synchronous active-high reset (clears all registers)
//               A   - HPE row-operand lanes, lane r = A[r*WIDTH +: WIDTH]
//               B   - VPE column-operand lanes, lane c = B[c*WIDTH +: WIDTH]
//               Y   - all accumulators, PE(0,0) in the most-significant slice
// Config      : SA_SIGNED_EN - when defined, operands are two's-complement and
//               the product is sign-extended before accumulation.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_2d #(
  parameter int WIDTH = 16,
  parameter int HPE   = 64,
  parameter int VPE   = 64
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [WIDTH*HPE-1:0]        A,
  input  logic [WIDTH*VPE-1:0]        B,
  output logic [2*WIDTH*HPE*VPE-1:0]  Y
);

  localparam int N  = HPE * VPE;
  localparam int AW = 2 * WIDTH;

  // Operand seen by each PE this cycle: an edge lane or the neighbour's register.
  logic [WIDTH-1:0] a_in [HPE][VPE];
  logic [WIDTH-1:0] b_in [HPE][VPE];

  for (genvar r = 0; r < HPE; r++) begin : g_row
    for (genvar c = 0; c < VPE; c++) begin : g_col
      logic [AW-1:0] acc;
      logic [AW-1:0] prod;

      if (c == 0) begin : g_a_edge
        assign a_in[r][c] = A[r*WIDTH +: WIDTH];
      end
      if (r == 0) begin : g_b_edge
        assign b_in[r][c] = B[c*WIDTH +: WIDTH];
      end

      // The rightmost a_reg and bottom b_reg would only feed nothing, so the
      // forwarding registers exist only where a downstream PE consumes them.
      if (c < VPE - 1) begin : g_a_fwd
        logic [WIDTH-1:0] a_reg;
        always_ff @(posedge CLK) begin
          if (RST) a_reg <= '0;
          else     a_reg <= a_in[r][c];
        end
        assign a_in[r][c+1] = a_reg;
      end

      if (r < HPE - 1) begin : g_b_fwd
        logic [WIDTH-1:0] b_reg;
        always_ff @(posedge CLK) begin
          if (RST) b_reg <= '0;
          else     b_reg <= b_in[r][c];
        end
        assign b_in[r+1][c] = b_reg;
      end

      // Operands are widened to the accumulator width first, so the low AW
      // bits of the AW-wide product are the exact full-precision product.
`ifdef SA_SIGNED_EN
      assign prod = {{WIDTH{a_in[r][c][WIDTH-1]}}, a_in[r][c]} *
                    {{WIDTH{b_in[r][c][WIDTH-1]}}, b_in[r][c]};
`else
      assign prod = {{WIDTH{1'b0}}, a_in[r][c]} *
                    {{WIDTH{1'b0}}, b_in[r][c]};
`endif

      // Wraps modulo 2^AW by construction.
      always_ff @(posedge CLK) begin
        if (RST) acc <= '0;
        else     acc <= acc + prod;
      end

      assign Y[(N-(r*VPE+c))*AW-1 -: AW] = acc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sa_2d.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa_2d
// Description : Self-checking bench for sa_2d (4x4, WIDTH=16). A per-edge
//               reference model produces the expected Y for every driven
//               cycle; expectations are queued and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_2d;
  localparam int W  = 16;
  localparam int H  = 4;
  localparam int V  = 4;
  localparam int N  = H * V;
  localparam int YW = 2 * W * N;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [W*H-1:0] A   = '0;
  logic [W*V-1:0] B   = '0;
  logic [YW-1:0]  Y;

  int n_tests = 0;
  int n_fail  = 0;

  sa_2d #(.WIDTH(W), .HPE(H), .VPE(V)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .Y(Y)
  );

  always #5 CLK = ~CLK;

  // Reference state
  logic [W-1:0]   m_a   [H][V];
  logic [W-1:0]   m_b   [H][V];
  logic [2*W-1:0] m_acc [H][V];
  logic [YW-1:0]  exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mul(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SA_SIGNED_EN
    int sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    return 32'(sx * sy);
`else
    return 32'(x) * 32'(y);
`endif
  endfunction

  function automatic logic [31:0] pe(input logic [YW-1:0] v, input int r, input int c);
    int k;
    k = r * V + c;
    return v[(N-k)*2*W-1 -: 2*W];
  endfunction

  // Apply one cycle of stimulus, advance the model, push the expected Y,
  // then compare the DUT just after the edge.
  task automatic step(input logic [W*H-1:0] a_v, input logic [W*V-1:0] b_v, input logic rst);
    logic [W-1:0]   na [H][V];
    logic [W-1:0]   nb [H][V];
    logic [2*W-1:0] nacc [H][V];
    logic [W-1:0]   ai, bi;
    logic [YW-1:0]  ev, got;
    A   = a_v;
    B   = b_v;
    RST = rst;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < V; c++) begin
        ai = (c == 0) ? a_v[r*W +: W] : m_a[r][c-1];
        bi = (r == 0) ? b_v[c*W +: W] : m_b[r-1][c];
        na[r][c]   = rst ? '0 : ai;
        nb[r][c]   = rst ? '0 : bi;
        nacc[r][c] = rst ? '0 : m_acc[r][c] + mul(ai, bi);
      end
    end
    ev = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < V; c++) begin
        m_a[r][c]   = na[r][c];
        m_b[r][c]   = nb[r][c];
        m_acc[r][c] = nacc[r][c];
        ev[(N-(r*V+c))*2*W-1 -: 2*W] = nacc[r][c];
      end
    end
    exp_q.push_back(ev);
    @(posedge CLK);
    #1;
    ev  = exp_q.pop_front();
    got = Y;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < V; c++)
        check_eq($sformatf("pe%0d_%0d", r, c), pe(got, r, c), pe(ev, r, c));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0);
  endtask

  initial begin
    logic [W*H-1:0] av;
    logic [W*V-1:0] bv;
    int lv;

    // Reset with non-zero operands present, then release with zeros.
    for (int i = 0; i < H; i++) av[i*W +: W] = 16'h1234;
    for (int i = 0; i < V; i++) bv[i*W +: W] = 16'h1234;
    step(av, bv, 1'b1);
    step(av, bv, 1'b1);
    check_eq("reset_pe00", pe(Y, 0, 0), 32'h0);
    check_eq("reset_pe33", pe(Y, 3, 3), 32'h0);
    idle(3);

    // Single product.
    av = '0; bv = '0;
    av[0 +: W] = 16'd3;
    bv[0 +: W] = 16'd5;
    step(av, bv, 1'b0);
    check_eq("single_pe00", pe(Y, 0, 0), 32'd15);
    idle(8);
    check_eq("single_hold", pe(Y, 0, 0), 32'd15);

    // Propagation along row 0 with B held at 1.
    step('0, '0, 1'b1);
    for (int i = 0; i < V; i++) bv[i*W +: W] = 16'd1;
    av = '0;
    av[0 +: W] = 16'd2;
    step(av, bv, 1'b0);
    check_eq("prop_c0", pe(Y, 0, 0), 32'd2);
    check_eq("prop_c1_early", pe(Y, 0, 1), 32'd0);
    for (int c = 1; c < V; c++) begin
      step('0, bv, 1'b0);
      check_eq($sformatf("prop_c%0d", c), pe(Y, 0, c), 32'd2);
      if (c < V - 1)
        check_eq($sformatf("prop_c%0d_early", c + 1), pe(Y, 0, c + 1), 32'd0);
    end
    check_eq("prop_row1", pe(Y, 1, 0), 32'd0);

    // Skewed 4x4 multiply.
    step('0, '0, 1'b1);
    for (int m = 0; m < 12; m++) begin
      av = '0; bv = '0;
      if (m <= 7) begin
        for (int n = 0; n < H; n++) begin
          lv = m + 1 - n;
          av[n*W +: W] = (lv > 0) ? W'(lv) : '0;
        end
        for (int n = 0; n < V; n++) begin
          lv = m + 1 - n;
          bv[n*W +: W] = (lv > 0) ? W'(lv) : '0;
        end
      end
      step(av, bv, 1'b0);
    end
    check_eq("skew_pe00", pe(Y, 0, 0), 32'd204);
    idle(2);

    // Accumulator wrap.
    step('0, '0, 1'b1);
    av = '0; bv = '0;
    av[0 +: W] = 16'hFFFF;
    bv[0 +: W] = 16'hFFFF;
    step(av, bv, 1'b0);
    step(av, bv, 1'b0);
`ifdef SA_SIGNED_EN
    check_eq("wrap_pe00", pe(Y, 0, 0), 32'h0000_0002);
`else
    check_eq("wrap_pe00", pe(Y, 0, 0), 32'hFFFC_0002);
`endif
    idle(2);

    // Signedness.
    step('0, '0, 1'b1);
    av = '0; bv = '0;
    av[0 +: W] = 16'hFFFF;
    bv[0 +: W] = 16'd2;
    step(av, bv, 1'b0);
`ifdef SA_SIGNED_EN
    check_eq("sign_pe00", pe(Y, 0, 0), 32'hFFFF_FFFE);
`else
    check_eq("sign_pe00", pe(Y, 0, 0), 32'h0001_FFFE);
`endif
    idle(3);

    // Reset mid-operation discards in-flight data.
    step(av, bv, 1'b0);
    step('0, '0, 1'b1);
    check_eq("midrst_pe00", pe(Y, 0, 0), 32'h0);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
